fetch_seq_ctrl: RTL and testbench
=================================

# fetch_seq_ctrl

Fetch sequencer for the in-order pipeline. It owns the program counter and drives the word address of the combinational instruction memory. Fetched {pc, instr} pairs go into a 2-entry buffer that feeds decode through a valid/ready handshake. It also applies control-flow redirects from execute and a halt request from the debug/control logic.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first PC fetched after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- imem_addr  output  30  instruction memory word index, = pc[31:2]; combinational from the pc register.
- imem_rdata  input  32  instruction word at imem_addr; valid in the same cycle.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
- halt_req  input  1  level; while high, no new fetches are buffered.
- if_valid  output  1  buffer head holds a valid instruction.
- if_pc  output  32  PC of the head entry; 0 when the buffer is empty.
- if_instr  output  32  instruction of the head entry; 0 when the buffer is empty.
- id_ready  input  1  decode accepts the head this cycle.
- halted  output  1  state is HALT and the buffer is empty.

## Operation
- State machine, 3 states:
  - BOOT: the single cycle after reset; no fetch. Always goes to RUN.
  - RUN: fetch every cycle that push is allowed. Goes to HALT when halt_req=1.
  - HALT: no pushes. Goes to RUN when halt_req=0.
- pop = if_valid & id_ready & ~redirect_valid.
- push = state==RUN & ~halt_req & ~redirect_valid & (count<2 | (count==2 & pop)).
- On push: write {pc, imem_rdata} at the tail, then pc <= pc + 4. The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- On redirect_valid:
  - Flush the buffer: count <= 0 and both pointers reset.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push and no pop that cycle.
  - Redirect is honored in every state: BOOT, RUN and HALT. The state is unchanged, except that BOOT still goes to RUN.
- Priority: redirect > halt > push/pop.
- Simultaneous push and pop with count==2: count stays 2, the head advances and the new entry fills the freed slot.
- Buffer: 2 entries, 1-bit read and write pointers, 2-bit count (0..2). No overflow or underflow is possible by construction. Assert count<=2 in simulation.
- halt_req rising while entries are buffered: the buffer drains normally to decode, and halted rises once count==0.

## Timing
- Reset values:
  - pc = RESET_PC; state = BOOT; count = 0; pointers = 0.
  - if_valid = 0; if_pc = 0; if_instr = 0; halted = 0.
  - imem_addr = RESET_PC[31:2].
- Reset asserted mid-operation discards all buffered entries immediately, since reset is asynchronous.
- Startup:
  - Edge 1 after reset deassertion: BOOT→RUN.
  - Edge 2: the RESET_PC entry is pushed; if_valid=1 after edge 2.
- Steady state with id_ready=1: one instruction per cycle. if_pc after successive edges reads P, P+4, P+8, …
- Redirect sampled at edge N: the buffer is empty after N. The target entry is pushed at N+1, so redirect-to-valid latency is 1 cycle.
- Backpressure: with id_ready=0 the buffer fills after 2 pushes, then pc holds. When id_ready returns, no instruction is lost or duplicated.
- halted is registered-state-derived (state==HALT & count==0) and has no combinational path from inputs.

## Test plan
- Reset then free-run, RESET_PC=32'h100, id_ready=1, memory word k = 32'hA000_0000+k. Required:
  - if_valid rises after edge 2.
  - if_pc = 100, 104, 108…
  - if_instr = A000_0040, A000_0041…
- Backpressure: id_ready=0 for 5 cycles after the first valid. Required:
  - count saturates at 2 and imem_addr holds at 0x42.
  - After release, the accepted sequence is contiguous 100, 104, 108… with no gaps or repeats.
- Redirect: redirect_valid with redirect_pc=32'h203 while 2 entries are buffered and id_ready=1. Required:
  - Next cycle if_valid=0.
  - Following cycle if_pc=200.
  - Neither flushed entry is ever accepted.
- Halt/resume:
  - halt_req=1 with 2 entries buffered → 2 pops, then halted=1 and imem_addr frozen.
  - Drop halt_req → fetch resumes from the frozen pc.
- Simultaneous redirect and halt: redirect_pc=32'h400 with halt_req=1. Required:
  - Buffer flushed; state HALT; no push.
  - On release, first if_pc = 400.
- PC wrap and async reset:
  - Redirect to 32'hFFFF_FFFC → if_pc shows FFFF_FFFC then 0.
  - Assert reset mid-stream → outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, fetches from a combinational instruction
// memory into a 2-entry {pc, instr} buffer, and serves decode via valid/ready.
// Redirects flush the buffer and retarget the PC; halt_req stops new fetches.
module fetch_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [29:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        id_ready,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [1:0][31:0] buf_pc_q, buf_pc_d;
   logic [1:0][31:0] buf_instr_q, buf_instr_d;
   logic             wptr_q, wptr_d;
   logic             rptr_q, rptr_d;
   logic [1:0]       count_q, count_d;
   logic             push, pop;
   logic             unused_redirect_lsbs;

   // Word-aligned redirect targets: the low bits carry no information.
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Outputs derived purely from registered state.
   always_comb begin
      imem_addr = pc_q[31:2];
      if_valid  = (count_q != 2'd0);
      if_pc     = if_valid ? buf_pc_q[rptr_q]    : '0;
      if_instr  = if_valid ? buf_instr_q[rptr_q] : '0;
      halted    = (state_q == ST_HALT) && (count_q == 2'd0);
   end

   // Next-state: FSM, PC, buffer pointers/count and tail write.
   always_comb begin
      pop  = if_valid & id_ready & ~redirect_valid;
      push = (state_q == ST_RUN) & ~halt_req & ~redirect_valid &
             ((count_q < 2'd2) | ((count_q == 2'd2) & pop));

      state_d     = state_q;
      pc_d        = pc_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;

      // Redirect leaves RUN/HALT untouched; BOOT always moves on.
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  if (!redirect_valid && halt_req)  state_d = ST_HALT;
         ST_HALT: if (!redirect_valid && !halt_req) state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase

      if (redirect_valid) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         wptr_d  = 1'b0;
         rptr_d  = 1'b0;
         count_d = 2'd0;
      end else begin
         // When full and popping, the tail slot equals the head being freed.
         if (push) begin
            buf_pc_d[wptr_q]    = pc_q;
            buf_instr_d[wptr_q] = imem_rdata;
            wptr_d              = ~wptr_q;
            pc_d                = pc_q + 32'd4;
         end
         if (pop) begin
            rptr_d = ~rptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
      end
   end

   // Buffer occupancy can never exceed its two entries.
   always_ff @(posedge clk) begin
      assert (count_q <= 2'd2);
   end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: directed scenarios plus a random
// run, all compared against a queue-based reference model of the fetch rules.
module tb_fetch_seq_ctrl;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [95:0] RESET_VEC = {1'b0, 32'h0, 32'h0, 1'b0, 30'h40};

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        id_ready;
   logic        halted;
   logic [95:0] observed;

   int checks = 0;
   int errors = 0;

   fetch_seq_ctrl #(.RESET_PC(RPC)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .id_ready       (id_ready),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   // Memory word k holds A000_0000 + k.
   assign imem_rdata = 32'hA000_0000 + {2'b00, imem_addr};
   assign observed   = {if_valid, if_pc, if_instr, halted, imem_addr};

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_boot;
   bit          m_halt;
   logic [31:0] acc[$];

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return 32'hA000_0000 + (a >> 2);
   endfunction

   function automatic logic [95:0] expected();
      if (mq.size() > 0)
         return {1'b1, mq[0].pc, mq[0].instr, 1'b0, m_pc[31:2]};
      return {1'b0, 64'h0, m_halt, m_pc[31:2]};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pc   = RPC;
      m_boot = 1'b1;
      m_halt = 1'b0;
   endtask

   // Advance model by one clock using the current inputs, then clock the DUT.
   task automatic tick();
      bit   pop, push;
      ent_t e;
      pop  = (mq.size() > 0) && id_ready && !redirect_valid;
      push = !m_boot && !m_halt && !halt_req && !redirect_valid &&
             ((mq.size() < 2) || pop);
      if (if_valid && id_ready && !redirect_valid) acc.push_back(if_pc);
      if (pop) void'(mq.pop_front());
      if (redirect_valid) begin
         mq.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
         e.pc    = m_pc;
         e.instr = mem_word(m_pc);
         mq.push_back(e);
         m_pc = m_pc + 32'd4;
      end
      if (m_boot) m_boot = 1'b0;
      else if (!redirect_valid) m_halt = halt_req;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt_req = 1'b0;
      id_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (observed !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_vec got %h want %h", observed, RESET_VEC);
      end
      tick();
      checks++;
      if (if_valid !== 1'b0) begin
         errors++;
         $display("FAIL boot_valid got %b want 0", if_valid);
      end
      tick();
      checks++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, 32'hA000_0040}) begin
         errors++;
         $display("FAIL first_fetch got %b %h %h want 1 00000100 a0000040", if_valid, if_pc, if_instr);
      end
   endtask

   task automatic test_free_run();
      id_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h104 + 32'(4 * i), 32'hA000_0041 + 32'(i)}) begin
            errors++;
            $display("FAIL free_run[%0d] got %b %h %h want 1 %h %h", i, if_valid, if_pc, if_instr,
                     32'h104 + 32'(4 * i), 32'hA000_0041 + 32'(i));
         end
         checks++;
         if (observed !== expected()) begin
            errors++;
            $display("FAIL free_run_model[%0d] got %h want %h", i, observed, expected());
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      tick();
      tick();
      acc.delete();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (observed !== expected()) begin
            errors++;
            $display("FAIL bp_hold[%0d] got %h want %h", i, observed, expected());
         end
      end
      checks++;
      if ({imem_addr, if_pc} !== {30'h42, 32'h100}) begin
         errors++;
         $display("FAIL bp_addr got %h/%h want 42/00000100", imem_addr, if_pc);
      end
      id_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (observed !== expected()) begin
            errors++;
            $display("FAIL bp_release[%0d] got %h want %h", i, observed, expected());
         end
      end
      checks++;
      if (acc.size() != 10) begin
         errors++;
         $display("FAIL bp_count got %0d want 10", acc.size());
      end
      for (int i = 0; i < acc.size(); i++) begin
         checks++;
         if (acc[i] !== 32'h100 + 32'(4 * i)) begin
            errors++;
            $display("FAIL bp_seq[%0d] got %h want %h", i, acc[i], 32'h100 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect();
      logic [31:0] f0;
      f0 = if_pc;
      acc.delete();
      redirect_valid = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (if_valid !== 1'b0 || observed !== expected()) begin
         errors++;
         $display("FAIL redir_flush got %h want %h", observed, expected());
      end
      tick();
      checks++;
      if ({if_pc, if_instr} !== {32'h200, 32'hA000_0080}) begin
         errors++;
         $display("FAIL redir_target got %h %h want 00000200 a0000080", if_pc, if_instr);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (acc.size() == 0 || acc[0] !== 32'h200) begin
         errors++;
         $display("FAIL redir_first_accept got %0d entries want first 00000200", acc.size());
      end
      foreach (acc[i]) begin
         checks++;
         if (acc[i] == f0 || acc[i] == f0 + 32'd4) begin
            errors++;
            $display("FAIL redir_flushed_accepted got %h want none of %h %h", acc[i], f0, f0 + 32'd4);
         end
      end
   endtask

   task automatic test_halt();
      logic [29:0] frz;
      id_ready = 1'b0;
      tick();
      acc.delete();
      halt_req = 1'b1;
      id_ready = 1'b1;
      tick();
      tick();
      checks++;
      if ({halted, if_valid} !== 2'b10 || acc.size() != 2) begin
         errors++;
         $display("FAIL halt_drain got halted=%b valid=%b pops=%0d want 1 0 2", halted, if_valid, acc.size());
      end
      frz = imem_addr;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (imem_addr !== frz || halted !== 1'b1 || observed !== expected()) begin
            errors++;
            $display("FAIL halt_frozen[%0d] got %h want %h", i, observed, expected());
         end
      end
      halt_req = 1'b0;
      tick();
      tick();
      checks++;
      if ({if_valid, if_pc} !== {1'b1, frz, 2'b00}) begin
         errors++;
         $display("FAIL halt_resume got %b %h want 1 %h", if_valid, if_pc, {frz, 2'b00});
      end
   endtask

   task automatic test_redirect_halt();
      redirect_valid = 1'b1;
      redirect_pc = 32'h400;
      halt_req = 1'b1;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (if_valid !== 1'b0 || observed !== expected()) begin
         errors++;
         $display("FAIL rh_flush got %h want %h", observed, expected());
      end
      tick();
      tick();
      checks++;
      if ({halted, if_valid, imem_addr} !== {1'b1, 1'b0, 30'h100}) begin
         errors++;
         $display("FAIL rh_halted got %b %b %h want 1 0 100", halted, if_valid, imem_addr);
      end
      halt_req = 1'b0;
      tick();
      tick();
      checks++;
      if ({if_valid, if_pc} !== {1'b1, 32'h400}) begin
         errors++;
         $display("FAIL rh_resume got %b %h want 1 00000400", if_valid, if_pc);
      end
   endtask

   task automatic test_wrap();
      id_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (if_pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_top got %h want fffffffc", if_pc);
      end
      tick();
      checks++;
      if ({if_pc, if_instr} !== {32'h0, 32'hA000_0000}) begin
         errors++;
         $display("FAIL wrap_zero got %h %h want 00000000 a0000000", if_pc, if_instr);
      end
   endtask

   task automatic test_async_reset();
      id_ready = 1'b0;
      tick();
      checks++;
      if (if_valid !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre got %b want 1", if_valid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (observed !== RESET_VEC) begin
         errors++;
         $display("FAIL areset_now got %h want %h", observed, RESET_VEC);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      tick();
      tick();
      checks++;
      if (observed !== expected()) begin
         errors++;
         $display("FAIL areset_restart got %h want %h", observed, expected());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         id_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
         if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
         tick();
         checks++;
         if (observed !== expected()) begin
            errors++;
            $display("FAIL random[%0d] got %h want %h", i, observed, expected());
         end
      end
      redirect_valid = 1'b0;
      halt_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt_req = 1'b0;
      id_ready = 1'b0;
      model_reset();
      test_reset();
      test_free_run();
      test_backpressure();
      test_redirect();
      test_halt();
      test_redirect_halt();
      test_wrap();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
